// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 8:1 mux: visits enabled channels in
// ascending order, settles, samples mux_out and publishes the byte.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] mask,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;

  logic [2:0] first_ch;
  logic [2:0] next_ch;
  logic       next_found;
  logic [7:0] sampled;

  // Lowest set bit of the incoming mask
  always_comb begin
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) first_ch = 3'(i);
    end
  end

  // Lowest enabled channel strictly above the current one
  always_comb begin
    next_ch    = 3'd0;
    next_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) > {1'b0, ch_q})) begin
        next_ch    = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  assign sampled = shadow_q | (8'(mux_out) << ch_q);

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          if (mask != 8'h00) begin
            mask_d   = mask;
            shadow_d = 8'h00;
            ch_d     = first_ch;
            sel_d    = first_ch;
            cnt_d    = SETTLE_C;
            state_d  = SCAN;
          end else begin
            data_d  = 8'h00;
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (abort) begin
          sel_d   = 3'd0;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          shadow_d = sampled;
          if (next_found) begin
            ch_d  = next_ch;
            sel_d = next_ch;
            cnt_d = SETTLE_C;
          end else begin
            data_d  = sampled;
            sel_d   = 3'd0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        sel_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= 3'd0;
      sel_q    <= 3'd0;
      cnt_q    <= 4'd0;
      mask_q   <= 8'h00;
      shadow_q <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);
  assign data = data_q;

endmodule
